decodificador_gestos: RTL and testbench

Parametrised, debounced successor to the combinational finger decoder: samples `N_DEDOS` finger-sensor lines, decodes them into a gesture code, and accepts a code only after it has held unchanged for `ESTABLE_CICLOS` consecutive cycles. Each newly accepted non-zero gesture is presented as a registered event on a valid/ready handshake with one-entry buffering and overflow flagging. It sits between the raw finger inputs and the gesture consumer, which is the command FSM of the final project.

---
 rtl/decodificador_gestos_pkg.sv | 29 ++
 rtl/decodificador_gestos_filtro.sv | 45 ++++
 rtl/decodificador_gestos.sv | 96 +++++++++
 tb/tb_decodificador_gestos.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decodificador_gestos_pkg.sv
// Shared types and helpers for the debounced gesture decoder.
// Provides the thermometer decode rule, the output-buffer state enum and gesture codes.
package gestos_pkg;

    localparam int MAX_DEDOS = 32;

    localparam int GESTO_NINGUNO = 0;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_buf_t;

    // A pattern of exactly k ones in bits [k-1:0], with k>=2 and k<=n, decodes to k-1.
    // Anything else (including a lone first finger) decodes to 0.
    function automatic logic [7:0] decodificar_dedos(input logic [MAX_DEDOS-1:0] e,
                                                      input int n);
        logic [MAX_DEDOS-1:0] patron;
        logic [7:0]           codigo;
        codigo = 8'd0;
        patron = MAX_DEDOS'(1);
        for (int k = 2; k <= MAX_DEDOS; k++) begin
            patron = {patron[MAX_DEDOS-2:0], 1'b1};
            if (k <= n && e == patron) codigo = 8'(k - 1);
        end
        return codigo;
    endfunction

endpackage

// File: rtl/decodificador_gestos_filtro.sv
// Stability filter: a code is accepted once it has been seen unchanged long enough.
// Raises a one-cycle evento when the accepted code changes to a non-zero value.
module filtro_estabilidad
    import gestos_pkg::*;
#(
    parameter int CW             = 2,
    parameter int ESTABLE_CICLOS = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] codigo_raw,
    output logic [CW-1:0] codigo_actual,
    output logic          evento,
    output logic [CW-1:0] codigo_evento
);

    localparam int             CNT_W   = $clog2(ESTABLE_CICLOS) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ESTABLE_CICLOS - 1);

    logic [CW-1:0]    codigo_cand;
    logic [CNT_W-1:0] cnt;
    logic             aceptar;

    // cnt saturates at CNT_MAX, so reaching it with a matching raw code means "held long enough".
    assign aceptar       = (codigo_raw == codigo_cand) && (cnt == CNT_MAX)
                           && (codigo_cand != codigo_actual);
    assign evento        = aceptar && (codigo_cand != CW'(GESTO_NINGUNO));
    assign codigo_evento = codigo_cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codigo_cand   <= '0;
            cnt           <= '0;
            codigo_actual <= '0;
        end else if (codigo_raw != codigo_cand) begin
            codigo_cand <= codigo_raw;
            cnt         <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else if (aceptar) begin
            codigo_actual <= codigo_cand;
        end
    end

endmodule

// File: rtl/decodificador_gestos.sv
// Debounced finger-gesture decoder with a one-entry valid/ready event buffer.
// Define DECOD_GESTOS_SINCRONIZADOR_EN for a 2-flop input synchroniser (else one input register).
module decodificador_gestos
    import gestos_pkg::*;
#(
    parameter int N_DEDOS        = 4,
    parameter int ESTABLE_CICLOS = 1000,
    localparam int CW            = $clog2(N_DEDOS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DEDOS-1:0] entrada,
    input  logic               gesto_listo,
    input  logic               borrar_desborde,
    output logic [CW-1:0]      gesto,
    output logic               gesto_valido,
    output logic [CW-1:0]      codigo_actual,
    output logic               desborde,
    output estado_buf_t        estado
);

    logic [N_DEDOS-1:0] entrada_s;
    logic [CW-1:0]      codigo_raw;
    logic               evento;
    logic [CW-1:0]      codigo_evento;

`ifdef DECOD_GESTOS_SINCRONIZADOR_EN
    logic [N_DEDOS-1:0] entrada_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entrada_m <= '0;
            entrada_s <= '0;
        end else begin
            entrada_m <= entrada;
            entrada_s <= entrada_m;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) entrada_s <= '0;
        else        entrada_s <= entrada;
    end
`endif

    assign codigo_raw = CW'(decodificar_dedos(MAX_DEDOS'(entrada_s), N_DEDOS));

    filtro_estabilidad #(
        .CW             (CW),
        .ESTABLE_CICLOS (ESTABLE_CICLOS)
    ) u_filtro (
        .clk           (clk),
        .rst_n         (rst_n),
        .codigo_raw    (codigo_raw),
        .codigo_actual (codigo_actual),
        .evento        (evento),
        .codigo_evento (codigo_evento)
    );

    // Handshake: an event transfers on every rising edge where gesto_valido=1 and
    // gesto_listo=1; gesto holds steady while gesto_valido=1 and gesto_listo=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= VACIO;
            gesto        <= '0;
            gesto_valido <= 1'b0;
            desborde     <= 1'b0;
        end else begin
            if (borrar_desborde) desborde <= 1'b0;
            case (estado)
                VACIO: begin
                    if (evento) begin
                        gesto        <= codigo_evento;
                        gesto_valido <= 1'b1;
                        estado       <= LLENO;
                    end
                end
                LLENO: begin
                    if (gesto_listo) begin
                        if (evento) begin
                            gesto <= codigo_evento;
                        end else begin
                            gesto_valido <= 1'b0;
                            estado       <= VACIO;
                        end
                    end else if (evento) begin
                        // Buffer full and not drained: drop the event; setting beats clearing.
                        desborde <= 1'b1;
                    end
                end
                default: estado <= VACIO;
            endcase
        end
    end

endmodule

// File: tb/tb_decodificador_gestos.sv
// Self-checking bench for decodificador_gestos (N_DEDOS=4, ESTABLE_CICLOS=4).
// Expected gesture events are queued at drive time and popped on each handshake.
module tb_decodificador_gestos;
    import gestos_pkg::*;

    localparam int N_DEDOS = 4;
    localparam int E       = 4;
    localparam int CW      = 2;
`ifdef DECOD_GESTOS_SINCRONIZADOR_EN
    localparam int LAT = E + 2;
`else
    localparam int LAT = E + 1;
`endif

    logic               clk;
    logic               rst_n;
    logic [N_DEDOS-1:0] entrada;
    logic               gesto_listo;
    logic               borrar_desborde;
    logic [CW-1:0]      gesto;
    logic               gesto_valido;
    logic [CW-1:0]      codigo_actual;
    logic               desborde;
    estado_buf_t        estado;

    int checks;
    int failures;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] modelo_actual;

    decodificador_gestos #(
        .N_DEDOS        (N_DEDOS),
        .ESTABLE_CICLOS (E)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .entrada         (entrada),
        .gesto_listo     (gesto_listo),
        .borrar_desborde (borrar_desborde),
        .gesto           (gesto),
        .gesto_valido    (gesto_valido),
        .codigo_actual   (codigo_actual),
        .desborde        (desborde),
        .estado          (estado)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [CW-1:0] modelo_decod(input logic [N_DEDOS-1:0] p);
        case (p)
            4'b0011: return 2'd1;
            4'b0111: return 2'd2;
            4'b1111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Inputs change 2 ns after a rising edge; outputs are read there or on the falling edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // scoreboard: pop on every handshake seen before the edge that completes it
    always @(negedge clk) begin
        if (rst_n && gesto_valido && gesto_listo) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got gesto=%0d, expected no event", gesto);
            end else begin
                logic [CW-1:0] e;
                e = exp_q.pop_front();
                if (gesto !== e) begin
                    failures++;
                    $display("FAIL sb_gesto: got %0d, expected %0d", gesto, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; entrada = 4'b1111; gesto_listo = 1'b0; borrar_desborde = 1'b0;
        steps(3);
        checks++;
        if ({gesto, gesto_valido, codigo_actual, desborde} !== 6'b0 || estado !== VACIO) begin
            failures++;
            $display("FAIL reset_hold: got g=%0d v=%0b a=%0d d=%0b s=%0d, expected all 0",
                     gesto, gesto_valido, codigo_actual, desborde, estado);
        end
        rst_n = 1'b1;
        steps(2);
        checks++;
        if ({gesto, gesto_valido, codigo_actual, desborde} !== 6'b0) begin
            failures++;
            $display("FAIL reset_release: got g=%0d v=%0b a=%0d d=%0b, expected all 0",
                     gesto, gesto_valido, codigo_actual, desborde);
        end
        entrada = 4'b0000;
        steps(E + 4);
        checks++;
        if (codigo_actual !== 2'd0 || gesto_valido !== 1'b0) begin
            failures++;
            $display("FAIL reset_flush: got a=%0d v=%0b, expected 0 0", codigo_actual, gesto_valido);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        entrada = 4'b0011;
        steps(3);
        entrada = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            if (codigo_actual !== 2'd0 || gesto_valido !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL glitch_short: got %0d bad cycles (last a=%0d), expected 0", bad, codigo_actual);
        end
        bad = 0;
        entrada = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            step();
            if (codigo_actual !== 2'd0 || gesto_valido !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL glitch_nonthermo: got %0d bad cycles (last a=%0d), expected 0", bad, codigo_actual);
        end
        entrada = 4'b0000;
        steps(2);
    endtask

    task automatic test_latency();
        entrada = 4'b0111;
        exp_q.push_back(modelo_decod(4'b0111));
        step();
        steps(LAT - 1);
        checks++;
        if (codigo_actual !== 2'd0 || gesto_valido !== 1'b0) begin
            failures++;
            $display("FAIL latency_early: got a=%0d v=%0b at t+%0d, expected 0 0",
                     codigo_actual, gesto_valido, LAT - 1);
        end
        step();
        checks++;
        if (codigo_actual !== 2'd2 || gesto_valido !== 1'b1 || gesto !== 2'd2) begin
            failures++;
            $display("FAIL latency_on_time: got a=%0d v=%0b g=%0d at t+%0d, expected 2 1 2",
                     codigo_actual, gesto_valido, gesto, LAT);
        end
        step();
        gesto_listo = 1'b1;
        step();
        gesto_listo = 1'b0;
        checks++;
        if (gesto_valido !== 1'b0 || codigo_actual !== 2'd2) begin
            failures++;
            $display("FAIL latency_handshake: got v=%0b a=%0d, expected 0 2", gesto_valido, codigo_actual);
        end
        modelo_actual = 2'd2;
    endtask

    task automatic test_overflow();
        entrada = 4'b0011;
        exp_q.push_back(2'd1);
        steps(LAT + 1);
        checks++;
        if (gesto_valido !== 1'b1 || gesto !== 2'd1 || desborde !== 1'b0) begin
            failures++;
            $display("FAIL ovf_first: got v=%0b g=%0d d=%0b, expected 1 1 0", gesto_valido, gesto, desborde);
        end
        entrada = 4'b1111;
        steps(LAT + 1);
        checks++;
        if (gesto !== 2'd1 || gesto_valido !== 1'b1 || desborde !== 1'b1 || codigo_actual !== 2'd3) begin
            failures++;
            $display("FAIL ovf_drop: got g=%0d v=%0b d=%0b a=%0d, expected 1 1 1 3",
                     gesto, gesto_valido, desborde, codigo_actual);
        end
        borrar_desborde = 1'b1;
        step();
        borrar_desborde = 1'b0;
        checks++;
        if (desborde !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got d=%0b, expected 0", desborde);
        end
        // second drop with the clear request on the very same edge
        entrada = 4'b0011;
        step();
        steps(LAT - 1);
        borrar_desborde = 1'b1;
        step();
        borrar_desborde = 1'b0;
        checks++;
        if (desborde !== 1'b1 || codigo_actual !== 2'd1 || gesto !== 2'd1) begin
            failures++;
            $display("FAIL ovf_set_wins: got d=%0b a=%0d g=%0d, expected 1 1 1", desborde, codigo_actual, gesto);
        end
        borrar_desborde = 1'b1;
        step();
        borrar_desborde = 1'b0;
        gesto_listo = 1'b1;
        step();
        gesto_listo = 1'b0;
        checks++;
        if (gesto_valido !== 1'b0 || desborde !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain: got v=%0b d=%0b, expected 0 0", gesto_valido, desborde);
        end
        modelo_actual = 2'd1;
    endtask

    task automatic test_simultaneous();
        entrada = 4'b0111;
        exp_q.push_back(2'd2);
        steps(LAT + 1);
        checks++;
        if (gesto_valido !== 1'b1 || gesto !== 2'd2) begin
            failures++;
            $display("FAIL simul_first: got v=%0b g=%0d, expected 1 2", gesto_valido, gesto);
        end
        entrada = 4'b1111;
        exp_q.push_back(2'd3);
        step();
        steps(LAT - 1);
        gesto_listo = 1'b1;
        step();
        checks++;
        if (gesto !== 2'd3 || gesto_valido !== 1'b1 || desborde !== 1'b0 || estado !== LLENO) begin
            failures++;
            $display("FAIL simul_replace: got g=%0d v=%0b d=%0b s=%0d, expected 3 1 0 1",
                     gesto, gesto_valido, desborde, estado);
        end
        step();
        gesto_listo = 1'b0;
        checks++;
        if (gesto_valido !== 1'b0 || estado !== VACIO) begin
            failures++;
            $display("FAIL simul_drain: got v=%0b s=%0d, expected 0 0", gesto_valido, estado);
        end
        modelo_actual = 2'd3;
    endtask

    task automatic test_reset_midcount();
        entrada = 4'b0011;
        steps(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gesto, gesto_valido, codigo_actual, desborde} !== 6'b0) begin
            failures++;
            $display("FAIL rst_mid_assert: got g=%0d v=%0b a=%0d d=%0b, expected all 0",
                     gesto, gesto_valido, codigo_actual, desborde);
        end
        step();
        rst_n = 1'b1;
        step();
        steps(LAT - 1);
        checks++;
        if (gesto_valido !== 1'b0 || codigo_actual !== 2'd0 || desborde !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_early: got v=%0b a=%0d d=%0b, expected 0 0 0",
                     gesto_valido, codigo_actual, desborde);
        end
        exp_q.push_back(2'd1);
        step();
        checks++;
        if (gesto_valido !== 1'b1 || gesto !== 2'd1 || codigo_actual !== 2'd1) begin
            failures++;
            $display("FAIL rst_mid_fresh: got v=%0b g=%0d a=%0d, expected 1 1 1",
                     gesto_valido, gesto, codigo_actual);
        end
        gesto_listo = 1'b1;
        step();
        gesto_listo = 1'b0;
        modelo_actual = 2'd1;
    endtask

    task automatic test_back_to_back();
        logic [N_DEDOS-1:0] pats [6];
        logic [N_DEDOS-1:0] p;
        logic [CW-1:0]      c;
        pats = '{4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b1011, 4'b0001};
        gesto_listo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p = pats[$urandom_range(0, 5)];
            c = modelo_decod(p);
            entrada = p;
            if (c != modelo_actual) begin
                modelo_actual = c;
                if (c != 2'd0) exp_q.push_back(c);
            end
            steps(LAT + 1);
            checks++;
            if (codigo_actual !== modelo_actual || desborde !== 1'b0) begin
                failures++;
                $display("FAIL b2b_code[%0d]: got a=%0d d=%0b, expected %0d 0",
                         i, codigo_actual, desborde, modelo_actual);
            end
        end
        steps(2);
        gesto_listo = 1'b0;
        step();
        checks++;
        if (gesto_valido !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: got v=%0b pending=%0d, expected 0 0", gesto_valido, exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        modelo_actual = '0;
        test_reset();
        test_glitch();
        test_latency();
        test_overflow();
        test_simultaneous();
        test_reset_midcount();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
